// File: rtl/cache_mem_arbiter_if.sv
// Cache-pair / RAM bus bundle for cache_mem_arbiter.
// slave is the arbiter's view; master is the caches-plus-RAM environment.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [31:0]       iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [31:0]       dstore;
  logic              dwait;
  logic [31:0]       dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [31:0]       ramstore;
  logic [31:0]       ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-requester RAM arbiter: dcache priority, one word per grant.
// Define CACHE_ARB_STARVE_GUARD_EN to bound icache wait to STARVE_LIMIT dcache completions.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 CLK,
  input logic                 RST,
  cache_mem_arbiter_if.slave  bus
);

  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic [1:0] {StIdle, StIgnt, StDgnt} state_e;

  state_e state_q;
  logic   d_req;
  logic   ram_access;
  logic   i_done;
  logic   d_done;
  logic   i_force;

  assign d_req      = bus.dREN | bus.dWEN;
  assign ram_access = (bus.ramstate == RamAccess);
  // Completion requires the request to still be live; a dropped request never sees a pulse.
  assign i_done     = (state_q == StIgnt) && bus.iREN && ram_access;
  assign d_done     = (state_q == StDgnt) && d_req && ram_access;

`ifdef CACHE_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q;

  assign i_force = bus.iREN && (starve_cnt_q == 3'(STARVE_LIMIT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt_q <= 3'd0;
    end else if (!bus.iREN || i_done) begin
      starve_cnt_q <= 3'd0;
    end else if (d_done && (starve_cnt_q != 3'd7)) begin
      starve_cnt_q <= starve_cnt_q + 3'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign i_force             = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_force) begin
            state_q <= StIgnt;
          end else if (d_req) begin
            state_q <= StDgnt;
          end else if (bus.iREN) begin
            state_q <= StIgnt;
          end
        end
        StIgnt:  if (!bus.iREN || ram_access) state_q <= StIdle;
        StDgnt:  if (!d_req || ram_access) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM side follows the granted requester's live inputs so per-word address changes pass through.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.iload    = 32'd0;
    bus.dwait    = 1'b1;
    bus.dload    = 32'd0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = 32'd0;
    unique case (state_q)
      StIgnt: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        if (i_done) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      StDgnt: begin
        bus.ramaddr = bus.daddr;
        if (bus.dWEN) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = bus.dstore;
        end else begin
          bus.ramREN = bus.dREN;
        end
        if (d_done) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule
